// File: rtl/flit_injector.sv
// flit_injector: host-side injection stage feeding a torus node's inject port.
// Buffers valid/ready requests in a small FIFO, packs each into a
// flit-with-children word stamped with this node's coordinates, and launches
// one flit per slot, paced by INJECT_GAP and the node's inject_stall.
// Optional feature macro: FLIT_INJ_SEQTAG_EN (tag field carries an internal
// 8-bit launch sequence number instead of req_tag).
module flit_injector #(
    parameter int unsigned cur_x        = 0,
    parameter int unsigned cur_y        = 0,
    parameter int unsigned cur_z        = 0,
    parameter int unsigned lg_numprocs  = 3,
    parameter int unsigned PayloadWidth = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned INJECT_GAP   = 0,
    localparam int unsigned FlitWidth   = PayloadWidth + 50,
    localparam int unsigned LevelWidth  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [PayloadWidth-1:0]          req_payload,
    input  logic [3:0]                       req_op,
    input  logic [1:0]                       req_alg,
    input  logic [7:0]                       req_tag,
    input  logic [7:0]                       req_ctx,
    input  logic [8:0]                       req_rank,
    input  logic [8:0]                       req_dst,
    input  logic [lg_numprocs-1:0]           req_children,
    input  logic                             inject_stall,
    output logic [FlitWidth+lg_numprocs-1:0] inject_flit,
    output logic [LevelWidth-1:0]            fifo_level,
    output logic [15:0]                      inj_count
);

    localparam int unsigned WordWidth = FlitWidth + lg_numprocs;
    localparam int unsigned AddrWidth = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrWidth  = AddrWidth + 1;
    localparam int unsigned GapWidth  = (INJECT_GAP > 0) ? $clog2(INJECT_GAP + 1) : 1;
    localparam int unsigned TagLo     = PayloadWidth + 6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GAP  = 1'b1
    } state_t;

    logic [WordWidth-1:0] mem [FIFO_DEPTH];
    logic [PtrWidth-1:0]  wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    logic                 full_c, empty_c, push_c, pop_c;
    logic [WordWidth-1:0] word_c;
    state_t               state_q, state_d;
    logic [GapWidth-1:0]  gap_q, gap_d;
    logic [WordWidth-1:0] flit_d;
    logic [15:0]          count_d;
`ifdef FLIT_INJ_SEQTAG_EN
    logic [7:0]           seq_q, seq_d;
`endif

    // FIFO status; pointers carry an extra wrap bit to separate full from empty
    assign empty_c    = (wr_ptr == rd_ptr);
    assign full_c     = (wr_ptr[AddrWidth] != rd_ptr[AddrWidth]) &&
                        (wr_ptr[AddrWidth-1:0] == rd_ptr[AddrWidth-1:0]);
    assign req_ready  = !full_c && !rst;
    assign push_c     = req_valid && req_ready;
    assign fifo_level = LevelWidth'(wr_ptr - rd_ptr);

    // Packed flit-with-children word; valid bit is set for every stored entry
    assign word_c = {req_children, 1'b1, req_dst,
                     3'(cur_z), 3'(cur_y), 3'(cur_x),
                     req_rank, req_ctx, req_tag, req_alg, req_op, req_payload};

    // Request storage; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr[AddrWidth-1:0]] <= word_c;
        end
    end

    // Launch FSM next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        flit_d   = '0;
        count_d  = inj_count;
        pop_c    = 1'b0;
`ifdef FLIT_INJ_SEQTAG_EN
        seq_d    = seq_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty_c && !inject_stall) begin
                    pop_c  = 1'b1;
                    flit_d = mem[rd_ptr[AddrWidth-1:0]];
`ifdef FLIT_INJ_SEQTAG_EN
                    flit_d[TagLo +: 8] = seq_q;
                    seq_d              = seq_q + 8'd1;
`endif
                    if (inj_count != 16'hFFFF) begin
                        count_d = inj_count + 16'd1;
                    end
                    if (INJECT_GAP > 0) begin
                        gap_d   = GapWidth'(INJECT_GAP);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q - GapWidth'(1);
                if (gap_q <= GapWidth'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        wr_ptr_d = wr_ptr + PtrWidth'(push_c);
        rd_ptr_d = rd_ptr + PtrWidth'(pop_c);
    end

    // State, pointer and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            inject_flit <= '0;
            inj_count   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
`ifdef FLIT_INJ_SEQTAG_EN
            seq_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            inject_flit <= flit_d;
            inj_count   <= count_d;
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
`ifdef FLIT_INJ_SEQTAG_EN
            seq_q       <= seq_d;
`endif
        end
    end

    // Lengths used only in some configurations
    logic unused_c;
    assign unused_c = ^{TagLo[0]};

endmodule

// File: tb/tb_flit_injector.sv
// Self-checking bench for flit_injector: a queue-based reference model predicts
// every output cycle for the main instance (gap 0, src 0,0,1); a second
// instance with INJECT_GAP=2 checks launch pacing.
module tb_flit_injector;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned GAPG  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid_g, inject_stall, stall_g;
    logic [31:0] req_payload;
    logic [3:0]  req_op;
    logic [1:0]  req_alg;
    logic [7:0]  req_tag, req_ctx;
    logic [8:0]  req_rank, req_dst;
    logic [2:0]  req_children;
    logic        req_ready, req_ready_g;
    logic [84:0] inject_flit, inject_flit_g;
    logic [2:0]  fifo_level, fifo_level_g;
    logic [15:0] inj_count, inj_count_g;

    always #5 clk = ~clk;

    flit_injector #(.cur_x(0), .cur_y(0), .cur_z(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_payload(req_payload), .req_op(req_op), .req_alg(req_alg),
        .req_tag(req_tag), .req_ctx(req_ctx), .req_rank(req_rank),
        .req_dst(req_dst), .req_children(req_children),
        .inject_stall(inject_stall), .inject_flit(inject_flit),
        .fifo_level(fifo_level), .inj_count(inj_count)
    );

    flit_injector #(.cur_x(2), .cur_y(3), .cur_z(4), .INJECT_GAP(GAPG)) dut_g (
        .clk(clk), .rst(rst), .req_valid(req_valid_g), .req_ready(req_ready_g),
        .req_payload(req_payload), .req_op(req_op), .req_alg(req_alg),
        .req_tag(req_tag), .req_ctx(req_ctx), .req_rank(req_rank),
        .req_dst(req_dst), .req_children(req_children),
        .inject_stall(stall_g), .inject_flit(inject_flit_g),
        .fifo_level(fifo_level_g), .inj_count(inj_count_g)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [84:0] mq[$];
    int          m_cyc, m_next, m_count;
    logic [7:0]  m_seq;
    logic [84:0] e_flit;
    int          e_level;
    logic        e_ready, m_acc, s_ready;

    function automatic logic [84:0] pack(input logic [31:0] p, input logic [3:0] op,
                                         input logic [1:0] alg, input logic [7:0] tag,
                                         input logic [7:0] ctx, input logic [8:0] rank,
                                         input logic [8:0] dst, input logic [2:0] ch,
                                         input logic [2:0] sx, input logic [2:0] sy,
                                         input logic [2:0] sz);
        return {ch, 1'b1, dst, sz, sy, sx, rank, ctx, tag, alg, op, p};
    endfunction

    task automatic new_fields();
        req_payload  = $urandom;
        req_op       = 4'($urandom);
        req_alg      = 2'($urandom);
        req_tag      = 8'($urandom);
        req_ctx      = 8'($urandom);
        req_rank     = 9'($urandom);
        req_dst      = 9'($urandom);
        req_children = 3'($urandom);
    endtask

    task automatic model_reset();
        mq.delete();
        m_cyc = 0; m_next = 0; m_count = 0; m_seq = 8'd0;
        e_flit = '0; e_level = 0;
    endtask

    // Predict the outputs after the coming edge from the current inputs
    task automatic model_edge();
        logic [84:0] w;
        e_ready = !rst && (mq.size() < DEPTH);
        m_acc   = req_valid && e_ready;
        e_flit  = '0;
        if (mq.size() > 0 && !inject_stall && m_cyc >= m_next) begin
            w = mq.pop_front();
`ifdef FLIT_INJ_SEQTAG_EN
            w[45:38] = m_seq;
            m_seq    = m_seq + 8'd1;
`endif
            e_flit = w;
            m_next = m_cyc + 1;
            if (m_count < 65535) m_count++;
        end
        if (m_acc)
            mq.push_back(pack(req_payload, req_op, req_alg, req_tag, req_ctx, req_rank,
                              req_dst, req_children, 3'd0, 3'd0, 3'd1));
        m_cyc++;
        e_level = mq.size();
    endtask

    task automatic step();
        s_ready = req_ready;
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (inject_flit !== 85'd0) begin fails++; $display("FAIL reset_flit got=%h exp=0", inject_flit); end
        tests++; if (inj_count !== 16'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", inj_count); end
        tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_in_rst got=%b exp=0", req_ready); end
        rst = 1'b0;
        model_reset();
        #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after got=%b exp=1", req_ready); end
    endtask

    task automatic test_basic();
        int nv = 0;
        req_payload = 32'hDEADBEEF; req_op = 4'd3; req_alg = 2'd1; req_tag = 8'h5A;
        req_ctx = 8'h11; req_rank = 9'd7; req_dst = 9'd0; req_children = 3'd2;
        inject_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = (i == 0);
            step();
            tests++;
            if (inject_flit !== e_flit || fifo_level !== 3'(e_level) || inj_count !== 16'(m_count) || s_ready !== e_ready) begin
                fails++;
                $display("FAIL basic_cycle%0d flit=%h/%h level=%0d/%0d count=%0d/%0d ready=%b/%b", i, inject_flit, e_flit, fifo_level, e_level, inj_count, m_count, s_ready, e_ready);
            end
            if (inject_flit[81] === 1'b1) begin
                nv++;
                tests++;
                if (i != 1 || inject_flit[84:82] !== 3'd2 || inject_flit[71:69] !== 3'd1 || inject_flit[31:0] !== 32'hDEADBEEF) begin
                    fails++;
                    $display("FAIL basic_fields at=%0d exp_at=1 ch=%0d src_z=%0d payload=%h", i, inject_flit[84:82], inject_flit[71:69], inject_flit[31:0]);
                end
            end
        end
        tests++; if (nv != 1) begin fails++; $display("FAIL basic_valid_cycles got=%0d exp=1", nv); end
    endtask

    task automatic test_full_fifo();
        int acc = 0;
        int nv  = 0;
        new_fields();
        inject_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = (acc < 6);
            step();
            if (m_acc) begin acc++; new_fields(); end
            tests++;
            if (inject_flit !== e_flit || fifo_level !== 3'(e_level) || inj_count !== 16'(m_count) || s_ready !== e_ready) begin
                fails++;
                $display("FAIL full_stalled%0d flit=%h/%h level=%0d/%0d count=%0d/%0d ready=%b/%b", i, inject_flit, e_flit, fifo_level, e_level, inj_count, m_count, s_ready, e_ready);
            end
        end
        tests++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL full_level got=%0d exp=4", fifo_level); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL full_ready got=%b exp=0", req_ready); end
        inject_stall = 1'b0;
        for (int i = 0; i < 14; i++) begin
            req_valid = (acc < 6);
            step();
            if (m_acc) begin acc++; new_fields(); end
            if (i < 4 && inject_flit[81] === 1'b1) nv++;
            tests++;
            if (inject_flit !== e_flit || fifo_level !== 3'(e_level) || inj_count !== 16'(m_count) || s_ready !== e_ready) begin
                fails++;
                $display("FAIL full_drain%0d flit=%h/%h level=%0d/%0d count=%0d/%0d ready=%b/%b", i, inject_flit, e_flit, fifo_level, e_level, inj_count, m_count, s_ready, e_ready);
            end
        end
        req_valid = 1'b0;
        tests++; if (nv != 4) begin fails++; $display("FAIL full_consecutive got=%0d exp=4", nv); end
    endtask

    task automatic test_stall();
        int nv = 0;
        int first = -1;
        new_fields();
        inject_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = (i == 0);
            step();
            if (inject_flit[81] === 1'b1) nv++;
            tests++;
            if (inject_flit !== e_flit || fifo_level !== 3'(e_level) || s_ready !== e_ready) begin
                fails++;
                $display("FAIL stall_hold%0d flit=%h/%h level=%0d/%0d ready=%b/%b", i, inject_flit, e_flit, fifo_level, e_level, s_ready, e_ready);
            end
        end
        req_valid = 1'b0;
        tests++; if (nv != 0) begin fails++; $display("FAIL stall_leak got=%0d exp=0", nv); end
        inject_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (inject_flit[81] === 1'b1) begin nv++; if (first < 0) first = i; end
            tests++;
            if (inject_flit !== e_flit || inj_count !== 16'(m_count)) begin
                fails++;
                $display("FAIL stall_release%0d flit=%h/%h count=%0d/%0d", i, inject_flit, e_flit, inj_count, m_count);
            end
        end
        tests++; if (nv != 1 || first != 0) begin fails++; $display("FAIL stall_once got=%0d@%0d exp=1@0", nv, first); end
    endtask

    task automatic test_gap();
        logic [84:0] gq[$];
        logic [84:0] w;
        logic [84:0] exp;
        stall_g = 1'b1;
        for (int k = 0; k < 3; k++) begin
            new_fields();
            req_valid_g = 1'b1;
            w = pack(req_payload, req_op, req_alg, req_tag, req_ctx, req_rank,
                     req_dst, req_children, 3'd2, 3'd3, 3'd4);
`ifdef FLIT_INJ_SEQTAG_EN
            w[45:38] = 8'(k);
`endif
            gq.push_back(w);
            tests++; if (req_ready_g !== 1'b1) begin fails++; $display("FAIL gap_ready%0d got=%b exp=1", k, req_ready_g); end
            @(posedge clk); @(negedge clk);
        end
        req_valid_g = 1'b0;
        tests++; if (fifo_level_g !== 3'd3) begin fails++; $display("FAIL gap_level got=%0d exp=3", fifo_level_g); end
        stall_g = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); @(negedge clk);
            exp = '0;
            if (k % (GAPG + 1) == 0 && gq.size() > 0) exp = gq.pop_front();
            tests++;
            if (inject_flit_g !== exp) begin fails++; $display("FAIL gap_slot%0d got=%h exp=%h", k, inject_flit_g, exp); end
        end
        tests++; if (inj_count_g !== 16'd3) begin fails++; $display("FAIL gap_count got=%0d exp=3", inj_count_g); end
    endtask

    task automatic test_random();
        new_fields();
        for (int i = 0; i < 310; i++) begin
            if (i < 300) begin
                req_valid    = ($urandom_range(0, 9) < 6);
                inject_stall = ($urandom_range(0, 9) < 3);
            end else begin
                req_valid    = 1'b0;
                inject_stall = 1'b0;
            end
            step();
            if (m_acc || !req_valid) new_fields();
            tests++;
            if (inject_flit !== e_flit || fifo_level !== 3'(e_level) || inj_count !== 16'(m_count) || s_ready !== e_ready) begin
                fails++;
                $display("FAIL random_cycle%0d flit=%h/%h level=%0d/%0d count=%0d/%0d ready=%b/%b", i, inject_flit, e_flit, fifo_level, e_level, inj_count, m_count, s_ready, e_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        inject_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            new_fields();
            req_valid = (i < 3);
            if (i == 3) inject_stall = 1'b0;
            step();
            tests++;
            if (inject_flit !== e_flit || fifo_level !== 3'(e_level)) begin
                fails++;
                $display("FAIL rmid_fill%0d flit=%h/%h level=%0d/%0d", i, inject_flit, e_flit, fifo_level, e_level);
            end
        end
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++; if (inject_flit !== 85'd0) begin fails++; $display("FAIL rmid_flit got=%h exp=0", inject_flit); end
        tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL rmid_level got=%0d exp=0", fifo_level); end
        tests++; if (inj_count !== 16'd0) begin fails++; $display("FAIL rmid_count got=%0d exp=0", inj_count); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if (inject_flit !== e_flit || fifo_level !== 3'(e_level) || inj_count !== 16'(m_count)) begin
                fails++;
                $display("FAIL rmid_after%0d flit=%h/%h level=%0d/%0d count=%0d/%0d", i, inject_flit, e_flit, fifo_level, e_level, inj_count, m_count);
            end
        end
    endtask

`ifdef FLIT_INJ_SEQTAG_EN
    task automatic test_seqtag();
        int n = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        inject_stall = 1'b0;
        new_fields();
        for (int i = 0; i < 300 && n < 258; i++) begin
            req_valid = 1'b1;
            step();
            if (m_acc) new_fields();
            tests++;
            if (inject_flit !== e_flit) begin fails++; $display("FAIL seq_cycle%0d flit=%h/%h", i, inject_flit, e_flit); end
            if (inject_flit[81] === 1'b1) begin
                tests++;
                if (inject_flit[45:38] !== 8'(n)) begin fails++; $display("FAIL seq_tag%0d got=%0d exp=%0d", n, inject_flit[45:38], n % 256); end
                n++;
            end
        end
        req_valid = 1'b0;
        tests++; if (n != 258) begin fails++; $display("FAIL seq_launches got=%0d exp=258", n); end
        repeat (DEPTH + 1) step();
    endtask
`endif

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_valid_g = 1'b0; inject_stall = 1'b0; stall_g = 1'b0;
        new_fields();
        model_reset();
        test_reset();
        test_basic();
        test_full_fifo();
        test_stall();
        test_gap();
        test_random();
        test_reset_mid();
`ifdef FLIT_INJ_SEQTAG_EN
        test_seqtag();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
